spec_free_list: RTL

SPEC_FREE_LIST -- requirements
Module: spec_free_list

---
 rtl/spec_free_list_pkg.sv | 27 ++
 rtl/spec_free_list_ptr_add.sv | 24 ++
 rtl/spec_free_list.sv | 130 +++++++++++++
 3 files changed

// File: rtl/spec_free_list_pkg.sv
// Shared configuration for the physical-register free list.
// Latency: none (constants only).
// Backpressure: none (constants only).
`ifndef SIZE_PHYSICAL_TABLE
`define SIZE_PHYSICAL_TABLE 96
`endif
`ifndef SIZE_RMT
`define SIZE_RMT 34
`endif
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif

package spec_free_list_pkg;
  // Non-architectural physical registers tracked by the free list
  localparam int FREE_LIST_DEPTH    = `SIZE_PHYSICAL_TABLE - `SIZE_RMT;
  localparam int SIZE_FREE_LIST_LOG = $clog2(FREE_LIST_DEPTH);
  // Widest lane group; sizes the per-cycle push/pop counts
  localparam int LANE_MAX   = (`DISPATCH_WIDTH > `COMMIT_WIDTH) ? `DISPATCH_WIDTH : `COMMIT_WIDTH;
  localparam int LANE_CNT_W = $clog2(LANE_MAX + 1);
endpackage

// File: rtl/spec_free_list_ptr_add.sv
// Modulo-DEPTH pointer increment: o_sum = (i_ptr + i_n) mod DEPTH, DEPTH any value.
// Latency: combinational.
// Backpressure: none; caller guarantees i_ptr < DEPTH and i_n < DEPTH.
module free_list_ptr_add #(
  parameter int DEPTH = 62,
  parameter int PTR_W = 6,
  parameter int N_W   = 3
) (
  input  logic [PTR_W-1:0] i_ptr,
  input  logic [N_W-1:0]   i_n,
  output logic [PTR_W-1:0] o_sum
);
  localparam logic [PTR_W:0] DEPTH_X = DEPTH[PTR_W:0];

  logic [PTR_W:0] w_raw;
  logic [PTR_W:0] w_wrap;

  // One-bit-wider sum, then a single conditional subtract for the wrap
  always_comb begin
    w_raw  = {1'b0, i_ptr} + {{(PTR_W + 1 - N_W){1'b0}}, i_n};
    w_wrap = w_raw - DEPTH_X;
    o_sum  = (w_raw >= DEPTH_X) ? w_wrap[PTR_W-1:0] : w_raw[PTR_W-1:0];
  end
endmodule

// File: rtl/spec_free_list.sv
// Circular free list of physical registers: rename pops from head, commit pushes at tail.
// Latency: freePhys_o combinational from head; pushes visible one cycle later.
// Backpressure: freeListEmpty_o when too few entries; pushes always accepted. Option: FREE_LIST_STALL_CNT_EN.
module spec_free_list
  import spec_free_list_pkg::*;
#(
  parameter int DEPTH = FREE_LIST_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall_i,
  input  logic [`DISPATCH_WIDTH-1:0]    reqFreeReg_i,
  output logic [`SIZE_PHYSICAL_LOG-1:0] freePhys_o [0:`DISPATCH_WIDTH-1],
  output logic                          freeListEmpty_o,
  input  logic [`COMMIT_WIDTH-1:0]      freedValid_i,
  input  logic [`SIZE_PHYSICAL_LOG-1:0] freedPhyReg_i [0:`COMMIT_WIDTH-1],
  input  logic                          recoverFlag_i
`ifdef FREE_LIST_STALL_CNT_EN
  ,
  output logic [31:0]                   stallCnt_o
`endif
);
  localparam int DW    = `DISPATCH_WIDTH;
  localparam int CW    = `COMMIT_WIDTH;
  localparam int RW    = `SIZE_PHYSICAL_LOG;
  localparam int CNT_W = PTR_W + 2;
  localparam int N_W   = LANE_CNT_W;

  logic [RW-1:0]    r_list [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W-1:0] r_arch_head;
  logic [CNT_W-1:0] r_count;

  logic [N_W-1:0]   w_pop_cnt;
  logic [N_W-1:0]   w_push_cnt;
  logic [N_W-1:0]   w_prefix [CW];
  logic [PTR_W-1:0] w_wr_idx [CW];
  logic [PTR_W-1:0] w_rd_idx [DW];
  logic [PTR_W-1:0] w_head_adv;
  logic [PTR_W-1:0] w_tail_adv;
  logic [PTR_W-1:0] w_arch_adv;
  logic             w_pop;
  logic [CNT_W-1:0] w_pop_amt;

  // Lane popcounts; each commit slot's write offset is the number of valid slots below it
  always_comb begin
    w_pop_cnt = '0;
    for (int k = 0; k < DW; k++) w_pop_cnt = w_pop_cnt + N_W'(reqFreeReg_i[k]);
    w_push_cnt = '0;
    for (int j = 0; j < CW; j++) begin
      w_prefix[j] = w_push_cnt;
      w_push_cnt  = w_push_cnt + N_W'(freedValid_i[j]);
    end
  end

  assign freeListEmpty_o = (r_count < CNT_W'(w_pop_cnt));
  assign w_pop           = !stall_i && !freeListEmpty_o && !recoverFlag_i;
  assign w_pop_amt       = w_pop ? CNT_W'(w_pop_cnt) : '0;

  free_list_ptr_add #(.DEPTH(DEPTH), .PTR_W(PTR_W), .N_W(N_W)) u_head_add (
    .i_ptr(r_head), .i_n(w_pop_cnt), .o_sum(w_head_adv));
  free_list_ptr_add #(.DEPTH(DEPTH), .PTR_W(PTR_W), .N_W(N_W)) u_tail_add (
    .i_ptr(r_tail), .i_n(w_push_cnt), .o_sum(w_tail_adv));
  free_list_ptr_add #(.DEPTH(DEPTH), .PTR_W(PTR_W), .N_W(N_W)) u_arch_add (
    .i_ptr(r_arch_head), .i_n(w_push_cnt), .o_sum(w_arch_adv));

  genvar g;
  generate
    for (g = 0; g < DW; g++) begin : g_rd
      free_list_ptr_add #(.DEPTH(DEPTH), .PTR_W(PTR_W), .N_W(N_W)) u_rd_add (
        .i_ptr(r_head), .i_n(N_W'(g)), .o_sum(w_rd_idx[g]));
      assign freePhys_o[g] = r_list[w_rd_idx[g]];
    end
    for (g = 0; g < CW; g++) begin : g_wr
      free_list_ptr_add #(.DEPTH(DEPTH), .PTR_W(PTR_W), .N_W(N_W)) u_wr_add (
        .i_ptr(r_tail), .i_n(w_prefix[g]), .o_sum(w_wr_idx[g]));
    end
  endgenerate

  // Pointer and occupancy update; recovery restores head to the committed position
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_arch_head <= '0;
      r_count     <= CNT_W'(DEPTH);
    end else begin
      r_tail      <= w_tail_adv;
      r_arch_head <= w_arch_adv;
      if (recoverFlag_i) begin
        r_head  <= w_arch_adv;
        r_count <= CNT_W'(DEPTH);
      end else begin
        if (w_pop) r_head <= w_head_adv;
        r_count <= r_count + CNT_W'(w_push_cnt) - w_pop_amt;
      end
    end
  end

  // Storage: reset to the registers beyond the architectural map, commit slots write at tail
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_list[i] <= RW'(i + `SIZE_RMT);
    end else begin
      for (int j = 0; j < CW; j++) begin
        if (freedValid_i[j]) r_list[w_wr_idx[j]] <= freedPhyReg_i[j];
      end
    end
  end

`ifdef FREE_LIST_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles in which rename was held off by the free list
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_stall_cnt <= '0;
    else if (freeListEmpty_o && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stallCnt_o = r_stall_cnt;
`endif

`ifndef SYNTHESIS
  // Commit can never free more registers than the list has room for
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (r_count + CNT_W'(w_push_cnt)) <= CNT_W'(DEPTH));
`endif
endmodule
